// File: rtl/lut4_cfg_loader_pkg.sv
// Shared definitions for the LUT4 config loader: FSM encoding, frame sizing
// and the mux4 primitive used to build the LUT read tree.
package lut4_cfg_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GET_LO = 2'd1,
        GET_HI = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam int LUT_INIT_W  = 16;
    localparam int FRAME_BYTES = 3;

    function automatic logic mux4(input logic [3:0] d, input logic [1:0] s);
        return d[s];
    endfunction

endpackage

// File: rtl/lut4_cfg_loader_eval.sv
// LUT4 evaluation: 16:1 mux of an INIT word, built as four mux4 leaves feeding
// one mux4 root. sel = {D,C,B,A}, A is the LSB.
module lut4_eval
    import lut4_cfg_loader_pkg::*;
(
    input  logic [LUT_INIT_W-1:0] init,
    input  logic [3:0]            sel,
    output logic                  y
);

    logic [3:0] leaf;

    always_comb begin
        leaf = '0;
        for (int g = 0; g < 4; g++) begin
            leaf[g] = mux4(init[4*g +: 4], sel[1:0]);
        end
        y = mux4(leaf, sel[3:2]);
    end

endmodule

// File: rtl/lut4_cfg_loader.sv
// Byte-serial loader for a bank of LUT4 cells plus a registered evaluation port.
// Frame = IDX, INIT[7:0], INIT[15:8]; the word is written in the COMMIT cycle.
module lut4_cfg_loader
    import lut4_cfg_loader_pkg::*;
#(
    parameter int                    NUM_LUTS     = 8,
    parameter int                    IDX_W        = 3,
    parameter logic [LUT_INIT_W-1:0] INIT_DEFAULT = 16'h0000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    output logic             s_ready,
    output logic             busy,
    output logic             wr_done,
    output logic             err_addr,
    input  logic             clr_err,
    input  logic [IDX_W-1:0] eval_sel,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    input  logic             D,
    output logic             Z,
    output logic [1:0]       dbg_state
);

    // Handshake: a byte transfers on a rising CLK edge when s_valid & s_ready;
    // s_ready depends only on the FSM state, never on s_valid.

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [7:0]              lo_q, lo_d;
    logic [7:0]              hi_q, hi_d;
    logic                    err_q, err_d;
    logic                    z_q, z_d;
    logic [LUT_INIT_W-1:0]   bank_q [NUM_LUTS];
    logic [LUT_INIT_W-1:0]   bank_d [NUM_LUTS];

    logic                    xfer;
    logic                    idx_ok;
    logic                    sel_ok;
    logic [LUT_INIT_W-1:0]   sel_init;
    logic                    eval_y;

    assign idx_ok = {1'b0, idx_q}    < (IDX_W+1)'(NUM_LUTS);
    assign sel_ok = {1'b0, eval_sel} < (IDX_W+1)'(NUM_LUTS);

    assign s_ready   = (state_q != COMMIT);
    assign busy      = (state_q != IDLE);
    assign wr_done   = (state_q == COMMIT) && idx_ok;
    assign err_addr  = err_q;
    assign Z         = z_q;
    assign dbg_state = state_q;
    assign xfer      = s_valid && s_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        bank_d  = bank_q;
        err_d   = err_q && !clr_err;
        case (state_q)
            IDLE: if (xfer) begin
                idx_d   = s_data[IDX_W-1:0];
                state_d = GET_LO;
            end
            GET_LO: if (xfer) begin
                lo_d    = s_data;
                state_d = GET_HI;
            end
            GET_HI: if (xfer) begin
                hi_d    = s_data;
                state_d = COMMIT;
            end
            COMMIT: begin
                state_d = IDLE;
                // Out-of-range index sets the sticky error, overriding clr_err.
                if (!idx_ok) err_d = 1'b1;
                for (int i = 0; i < NUM_LUTS; i++) begin
                    if (idx_q == IDX_W'(i)) bank_d[i] = {hi_q, lo_q};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Eval reads bank_q, so a cell written in COMMIT still shows its old INIT.
    always_comb begin
        sel_init = '0;
        for (int i = 0; i < NUM_LUTS; i++) begin
            if (eval_sel == IDX_W'(i)) sel_init = bank_q[i];
        end
        z_d = sel_ok && eval_y;
    end

    lut4_eval u_eval (
        .init (sel_init),
        .sel  ({D, C, B, A}),
        .y    (eval_y)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            err_q   <= 1'b0;
            z_q     <= INIT_DEFAULT[0];
            for (int i = 0; i < NUM_LUTS; i++) bank_q[i] <= INIT_DEFAULT;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            err_q   <= err_d;
            z_q     <= z_d;
            for (int i = 0; i < NUM_LUTS; i++) bank_q[i] <= bank_d[i];
        end
    end

endmodule

// File: tb/tb_lut4_cfg_loader.sv
// Scoreboard bench for lut4_cfg_loader: a frame-level reference model predicts
// every cycle's outputs; a monitor compares them on the falling edge.
module tb_lut4_cfg_loader;

    localparam int          NUM_LUTS = 8;
    localparam int          IDX_W    = 4;
    localparam logic [15:0] INIT_DEF = 16'h0000;

    logic             CLK = 1'b0;
    logic             RST;
    logic             s_valid;
    logic [7:0]       s_data;
    logic             s_ready, busy, wr_done, err_addr;
    logic             clr_err;
    logic [IDX_W-1:0] eval_sel;
    logic             A, B, C, D, Z;
    logic [1:0]       dbg_state;

    lut4_cfg_loader #(
        .NUM_LUTS     (NUM_LUTS),
        .IDX_W        (IDX_W),
        .INIT_DEFAULT (INIT_DEF)
    ) dut (
        .CLK (CLK), .RST (RST),
        .s_valid (s_valid), .s_data (s_data), .s_ready (s_ready),
        .busy (busy), .wr_done (wr_done), .err_addr (err_addr),
        .clr_err (clr_err), .eval_sel (eval_sel),
        .A (A), .B (B), .C (C), .D (D), .Z (Z),
        .dbg_state (dbg_state)
    );

    always #5 CLK = ~CLK;

    // Expected outputs per cycle, packed {s_ready, busy, wr_done, err_addr, Z}.
    logic [4:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: byte queue for the frame being received, pending commit.
    logic [15:0] m_bank [16];
    logic [7:0]  m_bytes[$];
    logic        m_commit;
    logic [3:0]  m_idx;
    logic [15:0] m_init;
    logic        m_err;
    logic        m_z;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_bank[i] = INIT_DEF;
        m_bytes.delete();
        m_commit = 1'b0;
        m_idx    = '0;
        m_init   = '0;
        m_err    = 1'b0;
        m_z      = INIT_DEF[0];
    endtask

    task automatic cycle(input logic v, input logic [7:0] d, input logic [3:0] sel,
                         input logic [3:0] abcd, input logic clr, input logic rst);
        logic bad;
        @(posedge CLK); #1;
        s_valid = v; s_data = d; eval_sel = sel; {D, C, B, A} = abcd;
        clr_err = clr; RST = rst;
        exp_q.push_back({!m_commit, m_commit || (m_bytes.size() != 0),
                         m_commit && (m_idx < NUM_LUTS), m_err, m_z});
        if (rst) begin
            model_reset();
        end else begin
            bad   = m_commit && (m_idx >= NUM_LUTS);
            m_z   = (sel < NUM_LUTS) ? m_bank[sel][abcd] : 1'b0;
            m_err = (m_err && !clr) || bad;
            if (m_commit) begin
                if (!bad) m_bank[m_idx] = m_init;
                m_commit = 1'b0;
            end else if (v) begin
                m_bytes.push_back(d);
                if (m_bytes.size() == 3) begin
                    m_idx    = m_bytes[0][3:0];
                    m_init   = {m_bytes[2], m_bytes[1]};
                    m_commit = 1'b1;
                    m_bytes.delete();
                end
            end
        end
    endtask

    task automatic idle(input logic [3:0] sel, input logic [3:0] abcd);
        cycle(1'b0, 8'h00, sel, abcd, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] i, input logic [7:0] lo, input logic [7:0] hi,
                              input logic [3:0] sel, input logic [3:0] abcd);
        cycle(1'b1, i,  sel, abcd, 1'b0, 1'b0);
        cycle(1'b1, lo, sel, abcd, 1'b0, 1'b0);
        cycle(1'b1, hi, sel, abcd, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, sel, abcd, 1'b0, 1'b0);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        logic [4:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_bit("s_ready",  s_ready,  e[4]);
            check_bit("busy",     busy,     e[3]);
            check_bit("wr_done",  wr_done,  e[2]);
            check_bit("err_addr", err_addr, e[1]);
            check_bit("Z",        Z,        e[0]);
        end
    end

    initial begin
        RST = 1'b1; s_valid = 1'b0; s_data = '0; clr_err = 1'b0;
        eval_sel = '0; {D, C, B, A} = 4'b0000;
        model_reset();
        repeat (3) @(posedge CLK);

        // Reset state, then eval of an all-zero cell.
        idle(4'd0, 4'b1111);
        idle(4'd0, 4'b1111);

        // Frame to cell 2, then probe three lookup indices.
        send_frame(8'h02, 8'hA5, 8'h3C, 4'd0, 4'b0000);
        idle(4'd2, 4'b0000);
        idle(4'd2, 4'b0001);
        idle(4'd2, 4'b1111);
        idle(4'd2, 4'b0000);

        // Out-of-range index: error sticks, then clears.
        send_frame(8'h09, 8'hFF, 8'hFF, 4'd1, 4'b0101);
        idle(4'd9, 4'b1111);
        idle(4'd1, 4'b0101);
        cycle(1'b0, 8'h00, 4'd2, 4'b0000, 1'b1, 1'b0);
        idle(4'd2, 4'b0000);

        // Two back-to-back frames with s_valid held high.
        for (int k = 0; k < 8; k++) begin
            logic [7:0] bytes_k [8];
            bytes_k = '{8'h05, 8'h34, 8'h12, 8'h00, 8'h06, 8'hCD, 8'hAB, 8'h00};
            cycle(1'b1, bytes_k[k], 4'd5, 4'b0010, 1'b0, 1'b0);
        end
        idle(4'd6, 4'b0000);
        idle(4'd5, 4'b0100);

        // Read-before-write while cell 4 is being written.
        send_frame(8'h04, 8'hFF, 8'hFF, 4'd4, 4'b0110);
        idle(4'd4, 4'b0110);
        idle(4'd4, 4'b0110);

        // Reset mid-frame, then a full frame parses from IDX.
        send_frame(8'h01, 8'h77, 8'h77, 4'd1, 4'b0000);
        cycle(1'b1, 8'h01, 4'd1, 4'b0000, 1'b0, 1'b0);
        cycle(1'b1, 8'h0F, 4'd1, 4'b0000, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 4'd1, 4'b0000, 1'b0, 1'b1);
        idle(4'd1, 4'b0000);
        send_frame(8'h03, 8'h80, 8'h00, 4'd1, 4'b0000);
        idle(4'd3, 4'b0111);
        idle(4'd3, 4'b0111);

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            logic [7:0] d;
            d = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) d = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 9))};
            cycle($urandom_range(0, 3) != 0, d, 4'($urandom_range(0, 9)),
                  4'($urandom_range(0, 15)), $urandom_range(0, 19) == 0,
                  $urandom_range(0, 199) == 0);
        end
        idle(4'd0, 4'b0000);

        @(negedge CLK); #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL exp_q_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
